// File: rtl/drive_bus_arbiter.sv
// drive_bus_arbiter: round-robin arbiter sharing one 8-bit drive bus between
// N requesters at burst granularity. All outputs are registered.
// Optional build macro DRIVE_ARB_STATS_EN adds the beat_cnt / trunc_cnt
// statistics outputs; without it those ports and counters do not exist.
// Handshake: a beat from requester k transfers on a posedge where
// req[k] & gnt[k] are both high; req is the valid, gnt the ready, and the
// accepted beat appears on in/valid one cycle later.
module drive_bus_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BEATS = 16,
  parameter int IDW       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     gnt,
  output logic [7:0]       in,
  output logic             valid,
  output logic             busy,
  output logic [IDW-1:0]   owner,
  output logic             trunc,
`ifdef DRIVE_ARB_STATS_EN
  output logic [31:0]      beat_cnt,
  output logic [15:0]      trunc_cnt,
`endif
  output logic             dbg_state
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [N-1:0]     gnt_n;
  logic [7:0]       in_n;
  logic             valid_n, busy_n, trunc_n;
  logic [IDW-1:0]   owner_n;
  logic [IDW-1:0]   win;
  logic             found;
  logic             cur_req, cur_last;
  logic [7:0]       cur_data;
  logic             accept;

  assign dbg_state = (state == BURST);

  // Round-robin search: first requester after the current owner, wrapping.
  always_comb begin
    win   = owner;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[k] && (k == (int'(owner) + i) % N)) begin
          found = 1'b1;
          win   = IDW'(k);
        end
      end
    end
  end

  // Select the request lane belonging to the current owner.
  always_comb begin
    cur_req  = 1'b0;
    cur_last = 1'b0;
    cur_data = '0;
    for (int k = 0; k < N; k++) begin
      if (owner == IDW'(k)) begin
        cur_req  = req[k];
        cur_last = req_last[k];
        cur_data = req_data[8*k +: 8];
      end
    end
  end

  assign accept = (state == BURST) && cur_req;

  // Next-state and next-output logic; valid/trunc default low, data holds.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt_n   = gnt;
    in_n    = in;
    valid_n = 1'b0;
    busy_n  = busy;
    owner_n = owner;
    trunc_n = 1'b0;
    case (state)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          state_n = BURST;
          owner_n = win;
          busy_n  = 1'b1;
          cnt_n   = '0;
          for (int k = 0; k < N; k++) gnt_n[k] = (win == IDW'(k));
        end
      end
      BURST: begin
        if (accept) begin
          in_n    = cur_data;
          valid_n = 1'b1;
          cnt_n   = cnt + 1'b1;
          // A burst ends on last, or is cut off at its MAX_BEATS-th beat.
          if (cur_last || (cnt == CW'(MAX_BEATS - 1))) begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
            trunc_n = !cur_last;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      gnt   <= '0;
      in    <= 8'h00;
      valid <= 1'b0;
      busy  <= 1'b0;
      owner <= IDW'(N - 1);
      trunc <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      in    <= in_n;
      valid <= valid_n;
      busy  <= busy_n;
      owner <= owner_n;
      trunc <= trunc_n;
    end
  end

`ifdef DRIVE_ARB_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      trunc_cnt <= '0;
    end else begin
      if (accept && (beat_cnt != 32'hFFFF_FFFF)) beat_cnt <= beat_cnt + 32'd1;
      if (trunc_n && (trunc_cnt != 16'hFFFF)) trunc_cnt <= trunc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_drive_bus_arbiter.sv
// Testbench for drive_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model and a data scoreboard.
module tb_drive_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 16;
  localparam int IDW  = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   gnt;
  logic [7:0]     in_bus;
  logic           valid;
  logic           busy;
  logic [IDW-1:0] owner;
  logic           trunc;
  logic           dbg_state;
`ifdef DRIVE_ARB_STATS_EN
  logic [31:0]    beat_cnt;
  logic [15:0]    trunc_cnt;
`endif

  drive_bus_arbiter #(.N(N), .MAX_BEATS(MAXB), .IDW(IDW)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .req_last(req_last),
    .gnt(gnt),
    .in(in_bus),
    .valid(valid),
    .busy(busy),
    .owner(owner),
    .trunc(trunc),
`ifdef DRIVE_ARB_STATS_EN
    .beat_cnt(beat_cnt),
    .trunc_cnt(trunc_cnt),
`endif
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  wire [16:0] obs = {gnt, valid, busy, trunc, owner, in_bus};
  logic [16:0] exp;

  function automatic logic [16:0] pack(logic [3:0] g, logic v, logic b, logic t,
                                       logic [1:0] o, logic [7:0] d);
    return {g, v, b, t, o, d};
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] exp_q[$];
  bit         m_busy;
  int         m_owner;
  int         m_cnt;
  logic [3:0] m_gnt;
  logic [7:0] m_in;
  bit         m_valid;
  bit         m_trunc;
  int         m_beats;
  int         m_truncs;

  // Predicts the registered outputs produced by the coming clock edge.
  task automatic model_edge();
    if (reset) begin
      m_busy = 0; m_owner = N - 1; m_cnt = 0; m_gnt = '0;
      m_in = 8'h00; m_valid = 0; m_trunc = 0; m_beats = 0; m_truncs = 0;
      exp_q.delete();
    end else begin
      m_valid = 0;
      m_trunc = 0;
      if (!m_busy) begin
        m_gnt = '0;
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (m_owner + i) % N;
          if (req[c]) begin
            m_owner = c; m_busy = 1; m_cnt = 0; m_gnt = 4'b0001 << c;
            break;
          end
        end
      end else if (req[m_owner]) begin
        m_in = req_data[8*m_owner +: 8];
        m_valid = 1;
        m_cnt++;
        m_beats++;
        exp_q.push_back(m_in);
        if (req_last[m_owner] || m_cnt == MAXB) begin
          m_trunc = !req_last[m_owner];
          if (m_trunc) m_truncs++;
          m_busy = 0;
          m_gnt = '0;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; req_data = '0; req_last = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; clear_inputs();
    tick(); tick();
    exp = pack(4'b0000, 0, 0, 0, 2'd3, 8'h00);
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_values got=%h want=%h", obs, exp); end
    reset = 1'b0;
    tick();
    total++; if (obs !== exp) begin bad++; $display("FAIL idle_no_req got=%h want=%h", obs, exp); end
  endtask

  task automatic test_single_burst();
    logic [7:0] beats [3];
    beats = '{8'h11, 8'h22, 8'h33};
    req = 4'b0001; req_data[7:0] = 8'h11; req_last = '0;
    tick();
    exp = pack(4'b0001, 0, 1, 0, 2'd0, 8'h00);
    total++; if (obs !== exp) begin bad++; $display("FAIL burst_grant got=%h want=%h", obs, exp); end
    for (int b = 0; b < 3; b++) begin
      req_data[7:0] = beats[b];
      req_last[0]   = (b == 2);
      tick();
      exp = (b == 2) ? pack(4'b0000, 1, 0, 0, 2'd0, beats[b])
                     : pack(4'b0001, 1, 1, 0, 2'd0, beats[b]);
      total++; if (obs !== exp) begin bad++; $display("FAIL burst_beat%0d got=%h want=%h", b, obs, exp); end
    end
    clear_inputs();
    tick();
    exp = pack(4'b0000, 0, 0, 0, 2'd0, 8'h33);
    total++; if (obs !== exp) begin bad++; $display("FAIL burst_after got=%h want=%h", obs, exp); end
  endtask

  // Runs after test_single_burst without reset: owner is 0, so 2 wins first.
  task automatic test_trunc();
    req = 4'b1100; req_last = '0; req_data[23:16] = 8'h01;
    tick();
    exp = pack(4'b0100, 0, 1, 0, 2'd2, 8'h33);
    total++; if (obs !== exp) begin bad++; $display("FAIL trunc_grant got=%h want=%h", obs, exp); end
    for (int b = 1; b <= 16; b++) begin
      req_data[23:16] = 8'(b);
      tick();
      exp = (b == 16) ? pack(4'b0000, 1, 0, 1, 2'd2, 8'(b))
                      : pack(4'b0100, 1, 1, 0, 2'd2, 8'(b));
      total++; if (obs !== exp) begin bad++; $display("FAIL trunc_beat%0d got=%h want=%h", b, obs, exp); end
    end
    req_data[23:16] = 8'd17;
    tick();
    exp = pack(4'b1000, 0, 1, 0, 2'd3, 8'd16);
    total++; if (obs !== exp) begin bad++; $display("FAIL trunc_next_grant got=%h want=%h", obs, exp); end
    clear_inputs();
    tick();
  endtask

  task automatic test_stats();
`ifdef DRIVE_ARB_STATS_EN
    total++; if (beat_cnt !== 32'd19) begin bad++; $display("FAIL stats_beats got=%0d want=19", beat_cnt); end
    total++; if (trunc_cnt !== 16'd1) begin bad++; $display("FAIL stats_truncs got=%0d want=1", trunc_cnt); end
`endif
  endtask

  task automatic test_round_robin();
    logic [3:0] got_g[$];
    logic [7:0] got_d[$];
    logic [3:0] want_g [5];
    logic [7:0] want_d [5];
    want_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    want_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    reset = 1'b1; clear_inputs(); tick(); reset = 1'b0;
    req = 4'b1111; req_last = 4'b1111;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gnt !== 4'b0000) got_g.push_back(gnt);
      if (valid === 1'b1) got_d.push_back(in_bus);
      total++;
      if ((valid === 1'b1) === (gnt !== 4'b0000)) begin
        bad++; $display("FAIL rr_gap c=%0d gnt=%b valid=%b", c, gnt, valid);
      end
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= got_g.size() || got_g[i] !== want_g[i]) begin
        bad++; $display("FAIL rr_grant%0d got=%b want=%b", i, (i < got_g.size()) ? got_g[i] : 4'bx, want_g[i]);
      end
      total++;
      if (i >= got_d.size() || got_d[i] !== want_d[i]) begin
        bad++; $display("FAIL rr_data%0d got=%h want=%h", i, (i < got_d.size()) ? got_d[i] : 8'hx, want_d[i]);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_bubble();
    reset = 1'b1; clear_inputs(); tick(); reset = 1'b0;
    req = 4'b0010; req_data[15:8] = 8'h51;
    tick();
    exp = pack(4'b0010, 0, 1, 0, 2'd1, 8'h00);
    total++; if (obs !== exp) begin bad++; $display("FAIL bubble_grant got=%h want=%h", obs, exp); end
    tick();
    exp = pack(4'b0010, 1, 1, 0, 2'd1, 8'h51);
    total++; if (obs !== exp) begin bad++; $display("FAIL bubble_beat1 got=%h want=%h", obs, exp); end
    req = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      tick();
      exp = pack(4'b0010, 0, 1, 0, 2'd1, 8'h51);
      total++; if (obs !== exp) begin bad++; $display("FAIL bubble_hold%0d got=%h want=%h", c, obs, exp); end
    end
    req = 4'b0011; req_data[15:8] = 8'h52; req_last[1] = 1'b1;
    tick();
    exp = pack(4'b0000, 1, 0, 0, 2'd1, 8'h52);
    total++; if (obs !== exp) begin bad++; $display("FAIL bubble_last got=%h want=%h", obs, exp); end
    req = 4'b0001; req_last = '0;
    tick();
    exp = pack(4'b0001, 0, 1, 0, 2'd0, 8'h52);
    total++; if (obs !== exp) begin bad++; $display("FAIL bubble_next got=%h want=%h", obs, exp); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; clear_inputs(); tick(); reset = 1'b0;
    req = 4'b0001; req_data[7:0] = 8'h61;
    tick(); tick();
    req_data[7:0] = 8'h62; reset = 1'b1;
    tick();
    exp = pack(4'b0000, 0, 0, 0, 2'd3, 8'h00);
    total++; if (obs !== exp) begin bad++; $display("FAIL midreset_outputs got=%h want=%h", obs, exp); end
    reset = 1'b0; req = 4'b0110;
    tick();
    exp = pack(4'b0010, 0, 1, 0, 2'd1, 8'h00);
    total++; if (obs !== exp) begin bad++; $display("FAIL midreset_regrant got=%h want=%h", obs, exp); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [7:0] d;
    reset = 1'b1; clear_inputs(); tick(); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++) begin
        req[k]            = ($urandom_range(0, 3) != 0);
        req_last[k]       = ($urandom_range(0, 9) == 0);
        req_data[8*k +: 8] = 8'($urandom);
      end
      tick();
      exp = pack(m_gnt, m_valid, m_busy, m_trunc, 2'(m_owner), m_in);
      total++; if (obs !== exp) begin bad++; $display("FAIL rand_outputs c=%0d got=%h want=%h", c, obs, exp); end
      if (valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_scoreboard c=%0d got=%h want=none", c, in_bus);
        end else begin
          d = exp_q.pop_front();
          if (in_bus !== d) begin bad++; $display("FAIL rand_scoreboard c=%0d got=%h want=%h", c, in_bus, d); end
        end
      end
`ifdef DRIVE_ARB_STATS_EN
      total++;
      if (beat_cnt !== 32'(m_beats) || trunc_cnt !== 16'(m_truncs)) begin
        bad++; $display("FAIL rand_stats c=%0d got=%0d/%0d want=%0d/%0d", c, beat_cnt, trunc_cnt, m_beats, m_truncs);
      end
`endif
    end
    clear_inputs(); reset = 1'b0;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_trunc();
    test_stats();
    test_round_robin();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
